// File: rtl/serial_frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_deserializer
// Purpose  : Frames a serial bit stream (start, LSB-first data, optional
//            parity, stop) into words held on a one-entry valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_deserializer #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_in,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int             CNT_W      = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_W - 1);
  localparam logic           c_par_en   = (PARITY_EN != 0);
  localparam logic           c_par_odd  = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]  r_shreg;
  logic               r_perr;
  logic               w_stop_good;
  logic               w_stop_bad;
  logic               w_accept;
  logic               w_load;
  logic               w_drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stop_good = 1'b0;
    w_stop_bad  = 1'b0;
    if (bit_en) begin
      case (r_state)
        S_IDLE: begin
          if (!data_in) w_state_nxt = S_DATA;
        end
        S_DATA: begin
          if (r_bit_cnt == c_last_bit) w_state_nxt = c_par_en ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          // A low stop bit only aborts the frame; it is never reused as a start bit.
          w_state_nxt = S_IDLE;
          w_stop_good = data_in;
          w_stop_bad  = ~data_in;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_accept = data_valid & data_ready;
  assign w_load   = w_stop_good & (~data_valid | data_ready);
  assign w_drop   = w_stop_good & data_valid & ~data_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_perr    <= 1'b0;
    end else if (bit_en) begin
      case (r_state)
        S_IDLE: begin
          if (!data_in) r_bit_cnt <= '0;
        end
        S_DATA: begin
          r_shreg[r_bit_cnt] <= data_in;
          r_bit_cnt          <= r_bit_cnt + CNT_W'(1);
        end
        S_PARITY: begin
          r_perr <= c_par_en & ((^r_shreg) ^ data_in ^ c_par_odd);
        end
        default: ;
      endcase
    end
  end

  // Handshake and error pulses run every cycle, independent of bit_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= w_stop_bad;
      overrun   <= w_drop;
      if (w_load) begin
        data_out   <= r_shreg;
        parity_err <= r_perr;
        data_valid <= 1'b1;
      end else if (w_accept) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_deserializer
// Purpose  : Scoreboard bench for serial_frame_deserializer (DATA_W=8, even).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         data_in;
  logic         bit_en;
  logic         data_ready;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         parity_err;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_cnt = 0;

  // Each entry is {parity_err, data}.
  logic [W:0] sb_q[$];
  logic [W:0] sb_exp;

  serial_frame_deserializer #(.DATA_W(W), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .bit_en     (bit_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Accepted words are compared against the scoreboard at the opposite edge.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
    if (busy)      busy_cnt++;
    if (data_valid && data_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got perr=%b data=%h, expected no word", parity_err, data_out);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({parity_err, data_out} !== sb_exp) begin
          errors++;
          $display("FAIL word: got perr=%b data=%h, expected perr=%b data=%h",
                   parity_err, data_out, sb_exp[W], sb_exp[W-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic flip, input logic stop,
                            input int gap, input logic rdy_at_stop);
    logic [W+2:0] bits;
    bits = {stop, (^d) ^ flip, d, 1'b0};
    for (int i = 0; i < W + 3; i++) begin
      if (i == W + 2 && rdy_at_stop) data_ready = 1'b1;
      data_in = bits[i];
      bit_en  = 1'b1;
      tick();
      bit_en  = 1'b0;
      repeat (gap) tick();
    end
    data_in = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", sb_q.size());
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({data_out, data_valid, parity_err, frame_err, overrun, busy} !== '0) begin
      errors++;
      $display("FAIL %s: got data=%h valid=%b perr=%b ferr=%b ovr=%b busy=%b, expected all 0",
               name, data_out, data_valid, parity_err, frame_err, overrun, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; data_in = 1'b1; bit_en = 1'b0; data_ready = 1'b0;
    repeat (2) tick();
    check_all_zero("reset_state");
    reset = 1'b1;
    tick();
  endtask

  task automatic test_frame();
    data_ready = 1'b1;
    busy_cnt = 0;
    sb_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 8'hA5) begin
      errors++;
      $display("FAIL frame_latency: got valid=%b data=%h, expected valid=1 data=a5", data_valid, data_out);
    end
    drain();
    tick();
    checks++;
    if (data_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_release: got valid=%b, expected 0", data_valid);
    end
    // Start bit is consumed from IDLE, so busy covers data, parity and stop.
    checks++;
    if (busy_cnt !== 10) begin
      errors++;
      $display("FAIL busy_cycles: got %0d, expected 10", busy_cnt);
    end
  endtask

  task automatic test_parity_err();
    fe_cnt = 0;
    sb_q.push_back({1'b1, 8'hA5});
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
    drain();
    checks++;
    if (fe_cnt !== 0) begin
      errors++;
      $display("FAIL parity_no_frame_err: got %0d frame_err pulses, expected 0", fe_cnt);
    end
  endtask

  task automatic test_frame_err();
    fe_cnt = 0;
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
    tick();
    checks++;
    if (fe_cnt !== 1 || data_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_err: got pulses=%0d valid=%b busy=%b, expected 1 0 0", fe_cnt, data_valid, busy);
    end
    repeat (3) tick();
    checks++;
    if (fe_cnt !== 1) begin
      errors++;
      $display("FAIL frame_err_pulse: got %0d pulses, expected 1", fe_cnt);
    end
  endtask

  task automatic test_overrun();
    data_ready = 1'b0;
    ov_cnt = 0;
    sb_q.push_back({1'b0, 8'h11});
    send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 0, 1'b0);
    tick();
    checks++;
    if (data_out !== 8'h11 || data_valid !== 1'b1 || ov_cnt !== 1) begin
      errors++;
      $display("FAIL overrun_hold: got data=%h valid=%b pulses=%0d, expected 11 1 1", data_out, data_valid, ov_cnt);
    end
    repeat (3) tick();
    checks++;
    if (ov_cnt !== 1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d pulses, expected 1", ov_cnt);
    end
    data_ready = 1'b1;
    drain();
    tick();
    checks++;
    if (data_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_release: got valid=%b, expected 0", data_valid);
    end
  endtask

  task automatic test_back_to_back();
    data_ready = 1'b0;
    ov_cnt = 0;
    sb_q.push_back({1'b0, 8'h11});
    send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0);
    sb_q.push_back({1'b0, 8'h22});
    send_frame(8'h22, 1'b0, 1'b1, 0, 1'b1);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 8'h22 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL drain_load: got valid=%b data=%h perr=%b, expected 1 22 0", data_valid, data_out, parity_err);
    end
    tick();
    checks++;
    if (ov_cnt !== 0) begin
      errors++;
      $display("FAIL drain_load_overrun: got %0d pulses, expected 0", ov_cnt);
    end
    drain();
    tick();
    checks++;
    if (data_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_load_release: got valid=%b, expected 0", data_valid);
    end
  endtask

  task automatic test_bit_en_gaps();
    data_ready = 1'b1;
    sb_q.push_back({1'b0, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b1, 2, 1'b0);
    drain();
    // Leave the word in data_out so the reset check below is meaningful.
    data_ready = 1'b0;
    sb_q.push_back({1'b0, 8'h0F});
    send_frame(8'h0F, 1'b0, 1'b1, 2, 1'b0);
    checks++;
    if (data_out !== 8'h0F || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL gap_hold: got data=%h valid=%b, expected 0f 1", data_out, data_valid);
    end
    void'(sb_q.pop_back());
  endtask

  task automatic test_reset_mid_frame();
    fe_cnt = 0;
    ov_cnt = 0;
    data_in = 1'b0; bit_en = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      data_in = i[0];
      tick();
    end
    bit_en = 1'b0;
    data_in = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid_frame");
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (fe_cnt !== 0 || ov_cnt !== 0) begin
      errors++;
      $display("FAIL reset_no_flags: got ferr=%0d ovr=%0d, expected 0 0", fe_cnt, ov_cnt);
    end
    data_ready = 1'b1;
    sb_q.push_back({1'b0, 8'h0F});
    send_frame(8'h0F, 1'b0, 1'b1, 0, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_bit_en_gaps();
    test_reset_mid_frame();
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
